// File: rtl/sort_pkg.sv
// Shared FSM encoding and vector sizing for the sorter scheduler.
package sort_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_SORT = 2'd1;
    localparam state_t S_RESP = 2'd2;

    function automatic int vec_w(input int dw, input int n);
        return dw * n;
    endfunction

endpackage

// File: rtl/parallel_sorter.sv
// Combinational odd-even transposition sort; ascending, element 0 smallest.
module parallel_sorter
    import sort_pkg::*;
#(
    parameter int DW = 3,
    parameter int N  = 4
) (
    input  logic [vec_w(DW, N)-1:0] inp,
    output logic [vec_w(DW, N)-1:0] outp
);

    logic [DW-1:0] e [N];
    logic [DW-1:0] t;

    // N alternating even/odd compare-exchange passes fully order N elements.
    always_comb begin
        t    = '0;
        outp = '0;
        for (int i = 0; i < N; i++) e[i] = inp[i*DW +: DW];
        for (int p = 0; p < N; p++) begin
            for (int i = 0; i < N - 1; i++) begin
                if (((i % 2) == (p % 2)) && (e[i] > e[i+1])) begin
                    t      = e[i];
                    e[i]   = e[i+1];
                    e[i+1] = t;
                end
            end
        end
        for (int i = 0; i < N; i++) outp[i*DW +: DW] = e[i];
    end

endmodule

// File: rtl/parallel_sorter_sched.sv
// Round-robin scheduler sharing one parallel_sorter between two requesters.
module parallel_sorter_sched
    import sort_pkg::*;
#(
    parameter int DW = 3,
    parameter int N  = 4,
    parameter int CW = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [vec_w(DW, N)-1:0] req0_data,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [vec_w(DW, N)-1:0] req1_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [vec_w(DW, N)-1:0] rsp_data,
    output logic                    rsp_id,
    output logic                    busy,
    output logic [CW-1:0]           sort_count
);

    localparam int VW = vec_w(DW, N);

    state_t        state;
    logic [VW-1:0] in_q;
    logic [VW-1:0] out_q;
    logic [VW-1:0] sorted;
    logic          id_q;
    logic          last_q;
    logic          gnt0;
    logic          gnt1;

    parallel_sorter #(.DW(DW), .N(N)) u_sorter (
        .inp  (in_q),
        .outp (sorted)
    );

    // On a tie the requester that did not win last time is granted.
    assign gnt0 = req0_valid && (!req1_valid || last_q);
    assign gnt1 = req1_valid && (!req0_valid || !last_q);

    // Gated by rst_n so readys are low while reset is held.
    assign req0_ready = rst_n && (state == S_IDLE) && gnt0;
    assign req1_ready = rst_n && (state == S_IDLE) && gnt1;

    assign rsp_valid = (state == S_RESP);
    assign rsp_data  = out_q;
    assign rsp_id    = id_q;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            in_q       <= '0;
            out_q      <= '0;
            id_q       <= 1'b0;
            last_q     <= 1'b1;
            sort_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt0 || gnt1) begin
                        in_q   <= gnt0 ? req0_data : req1_data;
                        id_q   <= gnt1;
                        last_q <= gnt1;
                        state  <= S_SORT;
                    end
                end
                S_SORT: begin
                    out_q <= sorted;
                    state <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        sort_count <= sort_count + CW'(1);
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
